// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: boot/run/halt/fault sequencing, next-PC selection,
// stall-time redirect capture and fetch-window legality checking.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned IM_WORDS    = 4096,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_valid,
  input  logic [25:0] j_index,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic [1:0]  state,
  output logic [31:0] exc_pc
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_RUN   = 2'b01,
    S_HALT  = 2'b10,
    S_FAULT = 2'b11
  } state_e;

  localparam logic [32:0] WIN_LO   = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI   = WIN_LO + (33'(IM_WORDS) * 33'd4);
  localparam logic [3:0]  BOOT_END = 4'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] exc_q, exc_d;

  logic [31:0] j_tgt;
  logic        redir_valid;
  logic [31:0] redir_tgt;
  logic [31:0] cand;
  logic        cand_legal;

  assign pc_plus4 = pc_q + 32'd4;
  assign j_tgt    = {pc_plus4[31:28], j_index, 2'b00};

  always_comb begin
    redir_valid = jr_valid | j_valid | (br_valid & br_taken);
    redir_tgt   = br_target;
    if (jr_valid)     redir_tgt = jr_target;
    else if (j_valid) redir_tgt = j_tgt;
  end

  always_comb begin
    cand = pc_plus4;
    if (pend_valid_q)     cand = pend_tgt_q;
    else if (redir_valid) cand = redir_tgt;
  end

  // 33-bit compare so a window ending at 2^32 cannot overflow
  assign cand_legal = (cand[1:0] == 2'b00) &&
                      ({1'b0, cand} >= WIN_LO) &&
                      ({1'b0, cand} <  WIN_HI);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    boot_cnt_d   = boot_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    exc_d        = exc_q;
    unique case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_END) state_d = S_RUN;
        else                        boot_cnt_d = boot_cnt_q + 4'd1;
      end
      S_RUN: begin
        if (stall) begin
          if (redir_valid) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = redir_tgt;
          end
        end else if (halt_req) begin
          state_d      = S_HALT;
          pend_valid_d = 1'b0;
        end else begin
          pend_valid_d = 1'b0;
          if (cand_legal) begin
            pc_d = cand;
          end else begin
            state_d = S_FAULT;
            exc_d   = cand;
          end
        end
      end
      S_HALT:  ;
      S_FAULT: ;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      boot_cnt_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
      exc_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      boot_cnt_q   <= boot_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      exc_q        <= exc_d;
    end
  end

  assign pc          = pc_q;
  assign state       = state_q;
  assign fetch_valid = (state_q == S_RUN);
  assign exc_pc      = exc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a behavioural PC model.
module tb_pc_sequencer;

  localparam longint unsigned RST_PC = 64'h3000;
  localparam longint unsigned WIN_SZ = 64'd4 * 64'd4096;
  localparam int              BOOTN  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, br_valid = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        j_valid = 1'b0;
  logic [25:0] j_index = '0;
  logic        jr_valid = 1'b0;
  logic [31:0] jr_target = '0;
  logic        halt_req = 1'b0;
  logic [31:0] pc, pc_plus4, exc_pc;
  logic        fetch_valid;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  // model: state as 0 boot,1 run,2 halt,3 fault
  longint unsigned m_pc, m_exc;
  int              m_st, m_boot;
  longint unsigned m_pend[$];

  pc_sequencer #(
    .RESET_PC   (32'h0000_3000),
    .IM_WORDS   (4096),
    .BOOT_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .j_valid(j_valid), .j_index(j_index),
    .jr_valid(jr_valid), .jr_target(jr_target),
    .halt_req(halt_req),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .state(state), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc, 32'(m_pc));
    chk({tag, ".pc4"},   pc_plus4, 32'((m_pc + 4) % (64'd1 << 32)));
    chk({tag, ".state"}, {30'd0, state}, 32'(m_st));
    chk({tag, ".fv"},    {31'd0, fetch_valid}, (m_st == 1) ? 32'd1 : 32'd0);
    chk({tag, ".exc"},   exc_pc, 32'(m_exc));
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_exc = 0; m_st = 0; m_boot = 0; m_pend.delete();
  endtask

  function automatic bit legal(input longint unsigned a);
    return (a % 4 == 0) && (a >= RST_PC) && (a < RST_PC + WIN_SZ);
  endfunction

  task automatic model_edge();
    longint unsigned seq, tgt, cand;
    bit have;
    seq  = (m_pc + 4) % (64'd1 << 32);
    have = 1'b1;
    if (jr_valid)                  tgt = jr_target;
    else if (j_valid)              tgt = (seq & 64'hF000_0000) + (longint'(j_index) * 4);
    else if (br_valid && br_taken) tgt = br_target;
    else begin have = 1'b0; tgt = seq; end
    case (m_st)
      0: if (m_boot == BOOTN - 1) m_st = 1; else m_boot++;
      1: begin
        if (stall) begin
          if (have) begin m_pend.delete(); m_pend.push_back(tgt); end
        end else if (halt_req) begin
          m_st = 2; m_pend.delete();
        end else begin
          cand = (m_pend.size() != 0) ? m_pend[0] : tgt;
          m_pend.delete();
          if (legal(cand)) m_pc = cand;
          else begin m_st = 3; m_exc = cand; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic idle();
    stall = 0; br_valid = 0; br_taken = 0; br_target = '0; j_valid = 0;
    j_index = '0; jr_valid = 0; jr_target = '0; halt_req = 0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 0;
    model_reset();
    #1 check_all("in_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic boot();
    do_reset();
    tick("boot1");
    tick("boot2");
  endtask

  function automatic logic [31:0] rnd_tgt();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'(RST_PC) + 32'($urandom_range(0, 4095) * 4) + 32'd2;
    if (r == 1) return 32'(RST_PC + WIN_SZ) + 32'($urandom_range(0, 3) * 4);
    if (r == 2) return 32'(RST_PC) - 32'd4;
    return 32'(RST_PC) + 32'($urandom_range(0, 4095) * 4);
  endfunction

  initial begin
    // reset and boot
    boot();
    chk("run_entry_state", {30'd0, state}, 32'd1);
    // branch taken / not taken
    br_valid = 1; br_taken = 1; br_target = 32'h3010;
    tick("br_taken");
    chk("br_taken_pc", pc, 32'h3010);
    br_taken = 0; br_target = 32'h3500;
    tick("br_not_taken");
    chk("br_nt_pc", pc, 32'h3014);
    idle();
    tick("seq");
    // jr, then j beating branch
    jr_valid = 1; jr_target = 32'h3008;
    tick("jr");
    idle();
    j_valid = 1; j_index = 26'h0C10; br_valid = 1; br_taken = 1; br_target = 32'h3200;
    tick("j_beats_br");
    chk("j_pc", pc, 32'h3040);
    // stall captures redirect
    idle(); stall = 1; jr_valid = 1; jr_target = 32'h3100;
    tick("stall_jr");
    idle();
    tick("pend_consume");
    chk("pend_pc", pc, 32'h3100);
    // newer redirect overwrites, halt ignored while stalled, pending beats jr
    stall = 1; br_valid = 1; br_taken = 1; br_target = 32'h3300; halt_req = 1;
    tick("stall_br");
    idle(); stall = 1; j_valid = 1; j_index = 26'h0D00;
    tick("stall_j");
    idle(); jr_valid = 1; jr_target = 32'h3400;
    tick("pend_beats_jr");
    chk("pend_over_pc", pc, 32'h3400);
    idle();
    tick("seq2");
    // misaligned fault
    jr_valid = 1; jr_target = 32'h3002;
    tick("fault_misalign");
    idle(); jr_valid = 1; jr_target = 32'h3100;
    tick("fault_sticky");
    // run off IM end
    boot();
    jr_valid = 1; jr_target = 32'h6FFC;
    tick("to_end");
    idle();
    tick("off_end");
    chk("off_end_exc", exc_pc, 32'h7000);
    // below window
    boot();
    br_valid = 1; br_taken = 1; br_target = 32'h2FFC;
    tick("below_win");
    // halt sticky
    boot();
    halt_req = 1; jr_valid = 1; jr_target = 32'h3100;
    tick("halt");
    for (int i = 0; i < 10; i++) begin
      jr_valid = 1; jr_target = 32'h3200; halt_req = 0; stall = i[0];
      tick("halt_sticky");
    end
    // async reset mid-cycle
    idle();
    @(posedge clk);
    #2 reset = 0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk) reset = 1;
    tick("post_async_boot");
    // randomized runs
    for (int run = 0; run < 12; run++) begin
      boot();
      for (int c = 0; c < 60; c++) begin
        stall     = ($urandom_range(0, 3) == 0);
        br_valid  = ($urandom_range(0, 2) == 0);
        br_taken  = $urandom_range(0, 1);
        br_target = rnd_tgt();
        j_valid   = ($urandom_range(0, 5) == 0);
        j_index   = 26'(32'(RST_PC / 4) + $urandom_range(0, 4095));
        jr_valid  = ($urandom_range(0, 5) == 0);
        jr_target = rnd_tgt();
        halt_req  = ($urandom_range(0, 63) == 0);
        tick("rand");
      end
    end
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
